nes_cpu_mem_bus: RTL
====================

# nes_cpu_mem_bus

Parametrised CPU-side memory subsystem for the 6502/NES core. It decodes the CPU address bus into RAM, IO-register, SRAM and ROM regions, with mirroring and per-region wait states. Wait states are signalled to the CPU through `rdy`. The block replaces the fixed-size memory arrays in the CPU test harness and is synthesisable for the FPGA top level.

## Interface
Parameters:
- `RAM_AW`, 11: RAM address bits; RAM is mirrored across 0x0000–0x1FFF.
- `IOREG_N`, 8: number of IO registers, power of two; mirrored across 0x2000–0x3FFF.
- `SRAM_AW`, 13: SRAM address bits; SRAM sits at 0x6000–0x7FFF and is mirrored if smaller.
- `ROM_AW`, 15: ROM address bits; ROM sits at 0x8000–0xFFFF and is mirrored if smaller.
- `WAIT_RAM`, 0: extra wait cycles for RAM accesses (0–7).
- `WAIT_IO`, 0: extra wait cycles for IO accesses (0–7).
- `WAIT_SRAM`, 0: extra wait cycles for SRAM accesses (0–7).
- `WAIT_ROM`, 1: extra wait cycles for ROM accesses (0–7).

Ports:
- `clk`  in  1  system clock; rising edge.
- `b_rst`  in  1  asynchronous, active-low reset.
- `cpu_addr_out`  in  16  CPU address.
- `cpu_data_out`  in  8  CPU write data.
- `ren`  in  1  read request.
- `wen`  in  1  write request.
- `cpu_data_in`  out  8  read data to CPU; registered.
- `rdy`  out  1  1 = bus ready / request accepted; 0 = wait state.
- `io_wr`  out  1  one-cycle pulse when an IO register is written.
- `io_idx`  out  $clog2(IOREG_N)  index of the IO register written.
- `io_data`  out  8  data written to the IO register.
- `bus_err`  out  1  sticky error flag; cleared only by reset.

## Operation
- Region decode uses `cpu_addr_out[15:13]`:
  - 000 → RAM
  - 001 → IO
  - 010 → unmapped (0x4000–0x5FFF)
  - 011 → SRAM
  - 1xx → ROM
- Array index is the low `*_AW` bits for memories and the low $clog2(IOREG_N) bits for IO.
- FSM states: IDLE, WAIT.
  - IDLE: at a rising edge with `rdy`=1 and (`ren`|`wen`), the address, write data and direction are latched. Let N be the wait count of the addressed region.
  - If N=0, the access executes at that same edge and the FSM stays in IDLE.
  - If N>0, the FSM goes to WAIT with a counter loaded to N, and `rdy`=0.
  - WAIT: the counter decrements each edge. On the edge where the counter reaches 1, the latched access executes, the FSM returns to IDLE, and `rdy`=1.
  - `ren`, `wen` and `cpu_addr_out` are ignored while in WAIT; the latched values are used.
- Executing a read: `cpu_data_in` is loaded from the addressed array.
- Unmapped read (open bus): `cpu_data_in` holds its previous value; no error.
- Executing a write to RAM, SRAM or IO: the array is written.
- IO write: `io_wr` pulses for the cycle following the executing edge, with `io_idx` and `io_data` valid in that cycle.
- ROM write and unmapped write: no array changes and `bus_err` is set. Unmapped reads do not set `bus_err`.
- `ren` and `wen` both high: treated as a write and `bus_err` is set.
- ROM contents are loaded by `$readmemh` from a file name supplied by the harness. RAM and SRAM contents are not reset.

## Timing
- Reset values:
  - `cpu_data_in` = 0x00
  - `rdy` = 1
  - `io_wr` = 0
  - `io_idx` = 0
  - `io_data` = 0x00
  - `bus_err` = 0
  - all IO registers = 0x00
  - FSM in IDLE
- Read latency is N+1 edges from the accepting edge to `cpu_data_in` valid: with N=0, data is valid immediately after the accepting edge.
- `rdy` falls right after the accepting edge when N>0 and stays low for exactly N cycles.
- Back-to-back accesses:
  - With N=0, a new request can be accepted every cycle.
  - With N>0, the next request can be accepted on the edge after `rdy` returns to 1.
- Reset asserted mid-WAIT: the pending access is dropped, with no write commit and no `io_wr`. All outputs return to their reset values asynchronously.
- Address wrap-around: 0xFFFF maps to ROM index `2**ROM_AW-1`; no carry into other regions.

## Test plan
- Reset, then read 0x0000 → `rdy`=1, `cpu_data_in`=0x00, `bus_err`=0.
- Write 0xA5 to 0x0012, then read 0x0812, 0x1012 and 0x1812 (mirrors) → each read returns 0xA5 one edge after acceptance.
- Read 0x8000 with ROM word 0x4C and `WAIT_ROM`=1 → `rdy`=0 for exactly 1 cycle, and `cpu_data_in`=0x4C when `rdy` returns to 1.
- Write 0x80 to 0x2008 with `IOREG_N`=8 → a single `io_wr` pulse with `io_idx`=0, `io_data`=0x80; a following read of 0x2000 returns 0x80.
- Write to 0x9000, then read 0x4000 → ROM is unchanged, `bus_err`=1 and stays 1; the read leaves `cpu_data_in` holding its prior value.
- `WAIT_SRAM`=3, write 0x77 to 0x6000, assert `b_rst` during the second wait cycle → all outputs are at reset values immediately; a read of 0x6000 after reset does not return 0x77 (pre-loaded value 0x00 returned).

Source files
------------

// File: rtl/nes_cpu_mem_bus.sv
// nes_cpu_mem_bus: CPU address decode into mirrored RAM/IO/SRAM/ROM
// with per-region wait states reported on rdy.
module nes_cpu_mem_bus #(
  parameter int    RAM_AW    = 11,
  parameter int    IOREG_N   = 8,
  parameter int    SRAM_AW   = 13,
  parameter int    ROM_AW    = 15,
  parameter int    WAIT_RAM  = 0,
  parameter int    WAIT_IO   = 0,
  parameter int    WAIT_SRAM = 0,
  parameter int    WAIT_ROM  = 1,
  localparam int   IW = (IOREG_N > 1) ? $clog2(IOREG_N) : 1
) (
  input  logic          clk,
  input  logic          b_rst,
  input  logic [15:0]   cpu_addr_out,
  input  logic [7:0]    cpu_data_out,
  input  logic          ren,
  input  logic          wen,
  output logic [7:0]    cpu_data_in,
  output logic          rdy,
  output logic          io_wr,
  output logic [IW-1:0] io_idx,
  output logic [7:0]    io_data,
  output logic          bus_err
);

  localparam logic [2:0] RG_RAM  = 3'd0;
  localparam logic [2:0] RG_IO   = 3'd1;
  localparam logic [2:0] RG_NONE = 3'd2;
  localparam logic [2:0] RG_SRAM = 3'd3;
  localparam logic [2:0] RG_ROM  = 3'd4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  localparam logic [2:0] N_RAM  = 3'(WAIT_RAM);
  localparam logic [2:0] N_IO   = 3'(WAIT_IO);
  localparam logic [2:0] N_SRAM = 3'(WAIT_SRAM);
  localparam logic [2:0] N_ROM  = 3'(WAIT_ROM);

  function automatic logic [2:0] rg_of(
    input logic [2:0] hi
  );
    case (hi)
      3'b000:  rg_of = RG_RAM;
      3'b001:  rg_of = RG_IO;
      3'b010:  rg_of = RG_NONE;
      3'b011:  rg_of = RG_SRAM;
      default: rg_of = RG_ROM;
    endcase
  endfunction

  function automatic logic [2:0] wait_of(
    input logic [2:0] rg
  );
    case (rg)
      RG_RAM:  wait_of = N_RAM;
      RG_IO:   wait_of = N_IO;
      RG_SRAM: wait_of = N_SRAM;
      RG_ROM:  wait_of = N_ROM;
      default: wait_of = 3'd0;
    endcase
  endfunction

  logic [7:0] ram_mem  [2**RAM_AW];
  logic [7:0] sram_mem [2**SRAM_AW];
  logic [7:0] rom_mem  [2**ROM_AW];
  logic [7:0] io_q     [IOREG_N];

  logic          state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          both_q, both_d;
  logic [7:0]    cpu_data_in_q, cpu_data_in_d;
  logic          io_wr_q, io_wr_d;
  logic [IW-1:0] io_idx_q, io_idx_d;
  logic [7:0]    io_data_q, io_data_d;
  logic          bus_err_q, bus_err_d;

  logic          exec;
  logic [15:0]   x_addr;
  logic [7:0]    x_wdata;
  logic          x_we;
  logic          x_both;
  logic [2:0]    x_rg;
  logic [2:0]    in_n;
  logic [7:0]    rdata;
  logic          ram_we;
  logic          sram_we;
  logic          io_we;
  logic          err;

  // Accept/wait sequencing; picks live or latched access to execute.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    both_d  = both_q;
    exec    = 1'b0;
    x_addr  = cpu_addr_out;
    x_wdata = cpu_data_out;
    x_we    = wen;
    x_both  = ren & wen;
    in_n    = wait_of(rg_of(cpu_addr_out[15:13]));
    if (state_q == ST_IDLE) begin
      if (ren | wen) begin
        addr_d  = cpu_addr_out;
        wdata_d = cpu_data_out;
        we_d    = wen;
        both_d  = ren & wen;
        if (in_n == 3'd0) begin
          exec = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = in_n;
        end
      end
    end else begin
      x_addr  = addr_q;
      x_wdata = wdata_q;
      x_we    = we_q;
      x_both  = both_q;
      cnt_d   = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        exec    = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  assign x_rg = rg_of(x_addr[15:13]);

  // Effects of the executing access: read data, writes, errors.
  always_comb begin
    case (x_rg)
      RG_RAM:  rdata = ram_mem[x_addr[RAM_AW-1:0]];
      RG_IO:   rdata = io_q[x_addr[IW-1:0]];
      RG_SRAM: rdata = sram_mem[x_addr[SRAM_AW-1:0]];
      RG_ROM:  rdata = rom_mem[x_addr[ROM_AW-1:0]];
      default: rdata = cpu_data_in_q;
    endcase
    ram_we  = exec & x_we & (x_rg == RG_RAM);
    sram_we = exec & x_we & (x_rg == RG_SRAM);
    io_we   = exec & x_we & (x_rg == RG_IO);
    err     = exec & (x_both | (x_we &
              ((x_rg == RG_ROM) | (x_rg == RG_NONE))));
    cpu_data_in_d = (exec & ~x_we) ? rdata
                                   : cpu_data_in_q;
    io_wr_d   = io_we;
    io_idx_d  = io_we ? x_addr[IW-1:0] : io_idx_q;
    io_data_d = io_we ? x_wdata : io_data_q;
    bus_err_d = bus_err_q | err;
  end

  // Control, output and IO register state.
  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      both_q        <= 1'b0;
      cpu_data_in_q <= '0;
      io_wr_q       <= 1'b0;
      io_idx_q      <= '0;
      io_data_q     <= '0;
      bus_err_q     <= 1'b0;
      for (int i = 0; i < IOREG_N; i++) begin
        io_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      both_q        <= both_d;
      cpu_data_in_q <= cpu_data_in_d;
      io_wr_q       <= io_wr_d;
      io_idx_q      <= io_idx_d;
      io_data_q     <= io_data_d;
      bus_err_q     <= bus_err_d;
      if (io_we) io_q[x_addr[IW-1:0]] <= x_wdata;
    end
  end

  // RAM and SRAM arrays keep their contents across reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[x_addr[RAM_AW-1:0]] <= x_wdata;
    if (sram_we) sram_mem[x_addr[SRAM_AW-1:0]] <= x_wdata;
  end

  assign cpu_data_in = cpu_data_in_q;
  assign rdy         = (state_q == ST_IDLE);
  assign io_wr       = io_wr_q;
  assign io_idx      = io_idx_q;
  assign io_data     = io_data_q;
  assign bus_err     = bus_err_q;

endmodule
